// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: widths, FSM state type and round constants.
// Imported by the key expansion top and its S-box sub-module.
package aes_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned KEY_W      = 128;
   localparam int unsigned NUM_ROUNDS = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      r = 8'h00;
      case (idx)
         4'd0: r = 8'h01;
         4'd1: r = 8'h02;
         4'd2: r = 8'h04;
         4'd3: r = 8'h08;
         4'd4: r = 8'h10;
         4'd5: r = 8'h20;
         4'd6: r = 8'h40;
         4'd7: r = 8'h80;
         4'd8: r = 8'h1b;
         4'd9: r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
// The table is packed MSB-first: entry 0 occupies bits [2047:2040].
module aes_sbox (
   input  logic [7:0] byte_i,
   output logic [7:0] byte_o
);

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] base;

   always_comb begin
      base   = 11'd2047 - {byte_i, 3'b000};
      byte_o = SBOX_TBL[base -: 8];
   end

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule: expands a cipher key into round keys 1..10, one per cycle,
// holding them in a register array until the next request or a disable.
module key_expansion
   import aes_pkg::*;
(
   input  logic             HCLK,
   input  logic             n_rst,
   input  logic             ena,
   input  logic             start,
   input  logic [KEY_W-1:0] keyword,
   output logic [KEY_W-1:0] subkey0,
   output logic [KEY_W-1:0] subkey1,
   output logic [KEY_W-1:0] subkey2,
   output logic [KEY_W-1:0] subkey3,
   output logic [KEY_W-1:0] subkey4,
   output logic [KEY_W-1:0] subkey5,
   output logic [KEY_W-1:0] subkey6,
   output logic [KEY_W-1:0] subkey7,
   output logic [KEY_W-1:0] subkey8,
   output logic [KEY_W-1:0] subkey9,
   output logic             busy,
   output logic             keys_valid
);

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [KEY_W-1:0]   work_q, work_d;
   logic [KEY_W-1:0]   subkey_q [NUM_ROUNDS];

   logic [WORD_W-1:0]  w0, w1, w2, w3;
   logic [WORD_W-1:0]  rot_w, sub_w, t_w;
   logic [WORD_W-1:0]  n0, n1, n2, n3;
   logic [KEY_W-1:0]   next_key;
   logic               wr_en;
   logic               clear;

   assign {w0, w1, w2, w3} = work_q;
   assign rot_w = {w3[23:0], w3[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_subword
      aes_sbox u_sbox (
         .byte_i (rot_w[8*b +: 8]),
         .byte_o (sub_w[8*b +: 8])
      );
   end

   always_comb begin
      t_w      = sub_w ^ {rcon(cnt_q), 24'h000000};
      n0       = w0 ^ t_w;
      n1       = w1 ^ n0;
      n2       = w2 ^ n1;
      n3       = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   // ena=0 outranks every state transition, including a start in the same cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      wr_en   = 1'b0;
      clear   = 1'b0;
      if (!ena) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         work_d  = '0;
         clear   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  work_d  = keyword;
                  cnt_d   = '0;
                  state_d = ST_EXPAND;
               end
            end
            ST_EXPAND: begin
               work_d = next_key;
               wr_en  = 1'b1;
               if (cnt_q == 4'(NUM_ROUNDS - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               work_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
      end
   end

   always_ff @(posedge HCLK or negedge n_rst) begin
      if (!n_rst) begin
         for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
            subkey_q[i] <= '0;
         end
      end else if (clear) begin
         for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
            subkey_q[i] <= '0;
         end
      end else if (wr_en) begin
         subkey_q[cnt_q] <= next_key;
      end
   end

   assign subkey0    = subkey_q[0];
   assign subkey1    = subkey_q[1];
   assign subkey2    = subkey_q[2];
   assign subkey3    = subkey_q[3];
   assign subkey4    = subkey_q[4];
   assign subkey5    = subkey_q[5];
   assign subkey6    = subkey_q[6];
   assign subkey7    = subkey_q[7];
   assign subkey8    = subkey_q[8];
   assign subkey9    = subkey_q[9];
   assign busy       = (state_q == ST_EXPAND);
   assign keys_valid = (state_q == ST_DONE);

endmodule
